// File: rtl/bmu_frame_ctrl.sv
// rtl/bmu_frame_ctrl.sv - Viterbi BMU frame sequencer: symbol intake, conditioning, drain, traceback, flush
//
// Purpose:
//   Sits in front of the branch-metric unit. Accepts soft symbol pairs over a
//   valid/ready handshake, saturates them into the 3-bit metric range and issues
//   one bmu_valid_o per accepted pair. Once a frame's symbols have all been
//   accepted, it waits for the BMU/ACS pipeline to drain, starts traceback and
//   then flushes the BMU for the next frame.
//
// Optional feature (macro VITERBI_PUNCT_EN):
//   Adds punct_i, which is latched with start_i. When the latched value is 1,
//   rate-2/3 depuncturing replaces Y with an erasure (255) on every odd symbol.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   start_i, frame_len_i frame start request and its length (honoured in IDLE only)
//   punct_i              depuncture enable (VITERBI_PUNCT_EN only)
//   sym_valid_i, sym_x_i, sym_y_i, sym_ready_o   upstream symbol handshake
//   acs_ready_i          downstream ACS can accept a metric set
//   bmu_valid_o, bmu_x_o, bmu_y_o, bmu_flush_o   BMU interface
//   tb_start_o, tb_done_i                         traceback handshake
//   busy_o, done_o, err_o, sym_cnt_o              status

module bmu_frame_ctrl #(
  parameter int LEN_W     = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] frame_len_i,
`ifdef VITERBI_PUNCT_EN
  input  logic             punct_i,
`endif
  input  logic             sym_valid_i,
  input  logic [7:0]       sym_x_i,
  input  logic [7:0]       sym_y_i,
  output logic             sym_ready_o,
  input  logic             acs_ready_i,
  output logic             bmu_valid_o,
  output logic [7:0]       bmu_x_o,
  output logic [7:0]       bmu_y_o,
  output logic             bmu_flush_o,
  output logic             tb_start_o,
  input  logic             tb_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] sym_cnt_o
);

  localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_TB    = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] sym_cnt_q;
  logic [DW-1:0]    drain_cnt_q;
  logic             tb_issued_q;
  logic             bmu_valid_q;
  logic [7:0]       bmu_x_q, bmu_y_q;
  logic             err_q;
  logic             punct_q;

  logic             start_ok;
  logic             start_bad;
  logic             xfer;
  logic             last_xfer;
  logic [7:0]       x_cond, y_cond;

  // Keeps values inside the 3-bit distance range; 255 is the erasure marker
  // and must survive untouched.
  function automatic logic [7:0] condition_sym(input logic [7:0] v);
    if (v == 8'd255) begin
      return v;
    end else if (v > 8'd7) begin
      return 8'd7;
    end else begin
      return v;
    end
  endfunction

  assign start_ok  = (state_q == S_IDLE) && start_i && (frame_len_i != '0);
  assign start_bad = (state_q == S_IDLE) && start_i && (frame_len_i == '0);

  // Ready drops once the count reaches the latched length, so the counter
  // can never wrap even at the maximum frame length.
  assign sym_ready_o = (state_q == S_RUN) && acs_ready_i && (sym_cnt_q < len_q);
  assign xfer        = sym_valid_i && sym_ready_o;
  assign last_xfer   = xfer && ((sym_cnt_q + LEN_W'(1)) == len_q);

  assign x_cond = condition_sym(sym_x_i);
`ifdef VITERBI_PUNCT_EN
  // Odd symbols (counted before this transfer) carry no Y under rate 2/3.
  assign y_cond = (punct_q && sym_cnt_q[0]) ? 8'd255 : condition_sym(sym_y_i);
`else
  assign y_cond = condition_sym(sym_y_i);
`endif

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    tb_start_o  = 1'b0;
    bmu_flush_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_xfer) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DW'(DRAIN_CYC - 1)) begin
          state_d = S_TB;
        end
      end
      S_TB: begin
        tb_start_o = !tb_issued_q;
        // A done seen in the same cycle as the start pulse cannot belong to
        // this frame's traceback, so it is only honoured afterwards.
        if (tb_issued_q && tb_done_i) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        bmu_flush_o = 1'b1;
        done_o      = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      sym_cnt_q   <= '0;
      drain_cnt_q <= '0;
      tb_issued_q <= 1'b0;
      bmu_valid_q <= 1'b0;
      bmu_x_q     <= '0;
      bmu_y_q     <= '0;
      err_q       <= 1'b0;
      punct_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bmu_valid_q <= xfer;
      err_q       <= start_bad;

      if (xfer) begin
        bmu_x_q <= x_cond;
        bmu_y_q <= y_cond;
      end

      if (start_ok) begin
        len_q <= frame_len_i;
`ifdef VITERBI_PUNCT_EN
        punct_q <= punct_i;
`else
        punct_q <= 1'b0;
`endif
      end

      if (start_ok || (state_q == S_FLUSH)) begin
        sym_cnt_q <= '0;
      end else if (xfer) begin
        sym_cnt_q <= sym_cnt_q + LEN_W'(1);
      end

      if (state_q == S_DRAIN) begin
        drain_cnt_q <= drain_cnt_q + DW'(1);
      end else begin
        drain_cnt_q <= '0;
      end

      tb_issued_q <= (state_q == S_TB);
    end
  end

  assign bmu_valid_o = bmu_valid_q;
  assign bmu_x_o     = bmu_x_q;
  assign bmu_y_o     = bmu_y_q;
  assign err_o       = err_q;
  assign sym_cnt_o   = sym_cnt_q;

endmodule

// File: tb/tb_bmu_frame_ctrl.sv
// tb/tb_bmu_frame_ctrl.sv - self-checking bench for bmu_frame_ctrl
module tb_bmu_frame_ctrl;

  localparam int LEN_W     = 16;
  localparam int DRAIN_CYC = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [LEN_W-1:0] frame_len_i = '0;
  logic             punct_i = 1'b0;
  logic             sym_valid_i = 1'b0;
  logic [7:0]       sym_x_i = '0;
  logic [7:0]       sym_y_i = '0;
  logic             sym_ready_o;
  logic             acs_ready_i = 1'b0;
  logic             bmu_valid_o;
  logic [7:0]       bmu_x_o, bmu_y_o;
  logic             bmu_flush_o;
  logic             tb_start_o;
  logic             tb_done_i = 1'b0;
  logic             busy_o, done_o, err_o;
  logic [LEN_W-1:0] sym_cnt_o;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: last values presented to the BMU (outputs hold between transfers).
  logic [7:0] last_x = 8'd0;
  logic [7:0] last_y = 8'd0;
  bit         punct_m = 1'b0;
  logic [7:0] stim_x[$];
  logic [7:0] stim_y[$];

  always #5 clk_i = ~clk_i;

  bmu_frame_ctrl #(.LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .frame_len_i (frame_len_i),
`ifdef VITERBI_PUNCT_EN
    .punct_i     (punct_i),
`endif
    .sym_valid_i (sym_valid_i),
    .sym_x_i     (sym_x_i),
    .sym_y_i     (sym_y_i),
    .sym_ready_o (sym_ready_o),
    .acs_ready_i (acs_ready_i),
    .bmu_valid_o (bmu_valid_o),
    .bmu_x_o     (bmu_x_o),
    .bmu_y_o     (bmu_y_o),
    .bmu_flush_o (bmu_flush_o),
    .tb_start_o  (tb_start_o),
    .tb_done_i   (tb_done_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .sym_cnt_o   (sym_cnt_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected conditioning: erasure kept, 0..7 kept, anything else clipped to 7.
  function automatic logic [7:0] ref_cond(input logic [7:0] v);
    if (v == 8'd255) return v;
    return (v > 8'd7) ? 8'd7 : v;
  endfunction

  function automatic logic [7:0] rnd_sym();
    case ($urandom_range(0, 3))
      0, 1:    return 8'($urandom_range(0, 7));
      2:       return 8'd255;
      default: return 8'($urandom_range(8, 254));
    endcase
  endfunction

  // Runs one complete frame against the model: start, symbol phase, drain,
  // traceback handshake and flush.
  task automatic run_frame(input int len, input bit rnd, input int stall_at, input bit poke);
    int         cnt = 0;
    int         stall_left = 5;
    int         guard = 0;
    int         k;
    int         w;
    bit         xfer;
    bit         exp_rdy;
    logic [7:0] ex, ey;

    start_i = 1'b1;
    frame_len_i = LEN_W'(len);
    punct_i = punct_m;
    tick();
    start_i = 1'b0;
    n_chk++;
    if (busy_o !== 1'b1 || sym_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL frame_start: busy=%0b cnt=%0d want busy=1 cnt=0", busy_o, sym_cnt_o);
    end

    while (cnt < len && guard < 2000) begin
      guard++;
      sym_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      acs_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (cnt == stall_at && stall_left > 0) begin
        acs_ready_i = 1'b0;
        stall_left--;
      end
      sym_x_i = (stim_x.size() > 0) ? stim_x[0] : rnd_sym();
      sym_y_i = (stim_y.size() > 0) ? stim_y[0] : rnd_sym();
      if (poke && guard == 1) begin
        start_i = 1'b1;
        frame_len_i = LEN_W'(5);
      end
      #1;
      exp_rdy = acs_ready_i && (cnt < len);
      n_chk++;
      if (sym_ready_o !== exp_rdy || sym_cnt_o !== LEN_W'(cnt)) begin
        n_fail++;
        $display("FAIL ready_cnt: ready=%0b cnt=%0d want ready=%0b cnt=%0d",
                 sym_ready_o, sym_cnt_o, exp_rdy, cnt);
      end
      xfer = sym_valid_i && exp_rdy;
      if (xfer) begin
        ex = ref_cond(sym_x_i);
        ey = (punct_m && (cnt % 2) == 1) ? 8'd255 : ref_cond(sym_y_i);
        last_x = ex;
        last_y = ey;
        if (stim_x.size() > 0) void'(stim_x.pop_front());
        if (stim_y.size() > 0) void'(stim_y.pop_front());
        cnt++;
      end
      tick();
      start_i = 1'b0;
      n_chk++;
      if (bmu_valid_o !== xfer || bmu_x_o !== last_x || bmu_y_o !== last_y) begin
        n_fail++;
        $display("FAIL bmu_out: valid=%0b x=%0d y=%0d want valid=%0b x=%0d y=%0d",
                 bmu_valid_o, bmu_x_o, bmu_y_o, xfer, last_x, last_y);
      end
    end
    n_chk++;
    if (cnt != len) begin
      n_fail++;
      $display("FAIL frame_timeout: sent=%0d want %0d", cnt, len);
    end

    // Drain: no symbols taken even with everything ready.
    sym_valid_i = 1'b1;
    acs_ready_i = 1'b1;
    #1;
    n_chk++;
    if (sym_ready_o !== 1'b0 || sym_cnt_o !== LEN_W'(len)) begin
      n_fail++;
      $display("FAIL drain_ready: ready=%0b cnt=%0d want ready=0 cnt=%0d", sym_ready_o, sym_cnt_o, len);
    end
    k = 1;
    while (!tb_start_o && k < 20) begin
      tick();
      k++;
    end
    sym_valid_i = 1'b0;
    n_chk++;
    if (tb_start_o !== 1'b1 || k != DRAIN_CYC + 1) begin
      n_fail++;
      $display("FAIL tb_start_lat: tb_start=%0b after %0d cycles want 1 after %0d", tb_start_o, k, DRAIN_CYC + 1);
    end

    // A done coincident with the start pulse must be ignored.
    tb_done_i = 1'b1;
    tick();
    tb_done_i = 1'b0;
    n_chk++;
    if (tb_start_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tb_wait: tb_start=%0b done=%0b busy=%0b want 0 0 1", tb_start_o, done_o, busy_o);
    end
    w = $urandom_range(0, 3);
    for (int i = 0; i < w; i++) tick();

    tb_done_i = 1'b1;
    tick();
    tb_done_i = 1'b0;
    n_chk++;
    if (bmu_flush_o !== 1'b1 || done_o !== 1'b1 || bmu_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: flush=%0b done=%0b valid=%0b want 1 1 0", bmu_flush_o, done_o, bmu_valid_o);
    end

    // Start during FLUSH is not honoured.
    start_i = 1'b1;
    frame_len_i = LEN_W'(3);
    tick();
    start_i = 1'b0;
    n_chk++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || bmu_flush_o !== 1'b0 || sym_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL post_flush: busy=%0b done=%0b flush=%0b cnt=%0d want 0 0 0 0",
               busy_o, done_o, bmu_flush_o, sym_cnt_o);
    end
    tick();
    n_chk++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start_ignored: busy=%0b want 0", busy_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    acs_ready_i = 1'b1;
    sym_valid_i = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({sym_ready_o, bmu_valid_o, bmu_flush_o, tb_start_o, busy_o, done_o, err_o} !== 7'b0 ||
        bmu_x_o !== 8'd0 || bmu_y_o !== 8'd0 || sym_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: flags=%07b x=%0d y=%0d cnt=%0d want all 0",
               {sym_ready_o, bmu_valid_o, bmu_flush_o, tb_start_o, busy_o, done_o, err_o},
               bmu_x_o, bmu_y_o, sym_cnt_o);
    end
    rst_ni = 1'b1;
    sym_valid_i = 1'b0;
    last_x = 8'd0;
    last_y = 8'd0;
    tick();
  endtask

  task automatic test_len4();
    run_frame(4, 1'b0, -1, 1'b0);
  endtask

  task automatic test_conditioning();
    stim_x = '{8'd3, 8'd200, 8'd255};
    stim_y = '{8'd255, 8'd9, 8'd0};
    run_frame(3, 1'b0, -1, 1'b0);
    n_chk++;
    if (last_x !== 8'd255 || last_y !== 8'd0) begin
      n_fail++;
      $display("FAIL cond_table: model x=%0d y=%0d want 255 0", last_x, last_y);
    end
  endtask

  task automatic test_backpressure();
    run_frame(6, 1'b0, 2, 1'b0);
  endtask

  task automatic test_err_and_ignore();
    start_i = 1'b1;
    frame_len_i = '0;
    tick();
    start_i = 1'b0;
    n_chk++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse: err=%0b busy=%0b want 1 0", err_o, busy_o);
    end
    tick();
    n_chk++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%0b busy=%0b want 0 0", err_o, busy_o);
    end
    run_frame(2, 1'b0, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1;
    frame_len_i = LEN_W'(8);
    tick();
    start_i = 1'b0;
    sym_valid_i = 1'b1;
    acs_ready_i = 1'b1;
    sym_x_i = 8'd1;
    sym_y_i = 8'd2;
    for (int i = 0; i < 3; i++) tick();
    n_chk++;
    if (sym_cnt_o !== LEN_W'(3)) begin
      n_fail++;
      $display("FAIL mid_count: cnt=%0d want 3", sym_cnt_o);
    end
    sym_valid_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    last_x = 8'd0;
    last_y = 8'd0;
    n_chk++;
    if ({sym_ready_o, bmu_valid_o, bmu_flush_o, tb_start_o, busy_o, done_o, err_o} !== 7'b0 ||
        bmu_x_o !== 8'd0 || bmu_y_o !== 8'd0 || sym_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: flags=%07b x=%0d y=%0d cnt=%0d want all 0",
               {sym_ready_o, bmu_valid_o, bmu_flush_o, tb_start_o, busy_o, done_o, err_o},
               bmu_x_o, bmu_y_o, sym_cnt_o);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_no_done: done=%0b busy=%0b want 0 0", done_o, busy_o);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(1, 12), 1'b1, -1, 1'b0);
    end
  endtask

`ifdef VITERBI_PUNCT_EN
  task automatic test_punct();
    stim_x = '{8'd1, 8'd1, 8'd1, 8'd1};
    stim_y = '{8'd2, 8'd2, 8'd2, 8'd2};
    punct_m = 1'b1;
    run_frame(4, 1'b0, -1, 1'b0);
    punct_m = 1'b0;
    n_chk++;
    if (last_y !== 8'd255) begin
      n_fail++;
      $display("FAIL punct_last: model y=%0d want 255", last_y);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_len4();
    test_conditioning();
    test_backpressure();
    test_err_and_ignore();
    test_reset_mid();
    test_random();
`ifdef VITERBI_PUNCT_EN
    test_punct();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
